// File: rtl/scif_host_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scif_host_bridge                                                         |
// | Host-side SCIF initiator: byte streams <-> 9-bit sclk-framed serial link.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module scif_host_bridge #(
  parameter int CLOCK_DIV     = 4,
  parameter int POLL_INTERVAL = 255
) (
  input  logic       core_clk,
  input  logic       reset_reset_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       scif_sclk,
  output logic       scif_txd,
  input  logic       scif_txr_n,
  input  logic       scif_rxd,
  output logic       scif_rxr_n,
  output logic       busy,
  output logic       rx_overrun
);

  localparam logic [1:0]  S_IDLE     = 2'd0;
  localparam logic [1:0]  S_SHIFT    = 2'd1;
  localparam logic [1:0]  S_GUARD    = 2'd2;
  localparam logic [8:0]  c_DIV_M1   = 9'(CLOCK_DIV - 1);
  localparam logic [8:0]  c_GUARD_M1 = 9'(2 * CLOCK_DIV - 1);
  localparam logic [15:0] c_POLL     = 16'(POLL_INTERVAL);

  logic        r_txr_s1;
  logic        r_txr_s2;
  logic [1:0]  r_state;
  logic [8:0]  r_cnt;
  logic [3:0]  r_bit;
  logic        r_sclk;
  logic        r_txd;
  logic [7:0]  r_tx_sh;
  logic [7:0]  r_rx_sh;
  logic        r_is_data;
  logic        r_rxr_n;
  logic        r_busy;
  logic [15:0] r_poll;
  logic        r_tx_full;
  logic [7:0]  r_tx_data;
  logic        r_out_valid;
  logic [7:0]  r_out_data;
  logic        r_ovr;

  logic        w_bit_end;
  logic        w_frame_end;
  logic [8:0]  w_rx_word;
  logic        w_start_data;
  logic        w_start_poll;

  // A bit ends on the last cycle of its sclk-high phase; that edge samples rxd.
  assign w_bit_end    = (r_state == S_SHIFT) && (r_cnt == c_DIV_M1) && r_sclk;
  assign w_frame_end  = w_bit_end && (r_bit == 4'd8);
  assign w_rx_word    = {r_rx_sh, scif_rxd};
  assign w_start_data = (r_state == S_IDLE) && r_tx_full && !r_txr_s2;
  assign w_start_poll = (r_state == S_IDLE) && !w_start_data &&
                        (r_poll == c_POLL) && !r_out_valid;

  always_ff @(posedge core_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_txr_s1 <= 1'b1;
      r_txr_s2 <= 1'b1;
    end else begin
      r_txr_s1 <= scif_txr_n;
      r_txr_s2 <= r_txr_s1;
    end
  end

  always_ff @(posedge core_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_tx_full <= 1'b0;
      r_tx_data <= 8'h00;
    end else if (w_frame_end && r_is_data) begin
      r_tx_full <= 1'b0;
    end else if (in_valid && !r_tx_full) begin
      r_tx_full <= 1'b1;
      r_tx_data <= in_data;
    end
  end

  always_ff @(posedge core_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_ovr       <= 1'b0;
    end else begin
      r_ovr <= w_frame_end && w_rx_word[8] && r_rxr_n;
      if (w_frame_end && w_rx_word[8] && !r_rxr_n) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_rx_word[7:0];
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge core_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 9'd0;
      r_bit     <= 4'd0;
      r_sclk    <= 1'b0;
      r_txd     <= 1'b0;
      r_tx_sh   <= 8'h00;
      r_rx_sh   <= 8'h00;
      r_is_data <= 1'b0;
      r_rxr_n   <= 1'b1;
      r_busy    <= 1'b0;
      r_poll    <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rxr_n <= r_out_valid;
          r_sclk  <= 1'b0;
          r_txd   <= 1'b0;
          if (w_start_data || w_start_poll) begin
            r_state   <= S_SHIFT;
            r_cnt     <= 9'd0;
            r_bit     <= 4'd0;
            r_busy    <= 1'b1;
            r_poll    <= 16'd0;
            r_is_data <= w_start_data;
            r_txd     <= w_start_data;
            r_tx_sh   <= w_start_data ? r_tx_data : 8'h00;
          end else if (r_poll != c_POLL) begin
            r_poll <= r_poll + 16'd1;
          end
        end
        S_SHIFT: begin
          if (r_cnt == c_DIV_M1) begin
            r_cnt <= 9'd0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              r_sclk  <= 1'b0;
              r_rx_sh <= {r_rx_sh[6:0], scif_rxd};
              if (r_bit == 4'd8) begin
                r_state <= S_GUARD;
                r_txd   <= 1'b0;
              end else begin
                r_bit   <= r_bit + 4'd1;
                r_txd   <= r_tx_sh[7];
                r_tx_sh <= {r_tx_sh[6:0], 1'b0};
              end
            end
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end
        S_GUARD: begin
          if (r_cnt == c_GUARD_M1) begin
            r_state <= S_IDLE;
            r_cnt   <= 9'd0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = !r_tx_full;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign scif_sclk  = r_sclk;
  assign scif_txd   = r_txd;
  assign scif_rxr_n = r_rxr_n;
  assign busy       = r_busy;
  assign rx_overrun = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_scif_host_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_scif_host_bridge                                                      |
// | Directed bench: one bridge at CLOCK_DIV=2/POLL=16, one at CLOCK_DIV=1.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_scif_host_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_in_valid, a_out_ready, a_txr_n, a_rxd;
  logic [7:0] a_in_data;
  logic       a_in_ready, a_out_valid, a_sclk, a_txd, a_rxr_n, a_busy, a_ovr;
  logic [7:0] a_out_data;

  logic       b_rst_n, b_in_valid, b_out_ready, b_txr_n, b_rxd;
  logic [7:0] b_in_data;
  logic       b_in_ready, b_out_valid, b_sclk, b_txd, b_rxr_n, b_busy, b_ovr;
  logic [7:0] b_out_data;

  scif_host_bridge #(.CLOCK_DIV(2), .POLL_INTERVAL(16)) u_a (
    .core_clk(clk), .reset_reset_n(a_rst_n),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .scif_sclk(a_sclk), .scif_txd(a_txd), .scif_txr_n(a_txr_n),
    .scif_rxd(a_rxd), .scif_rxr_n(a_rxr_n), .busy(a_busy), .rx_overrun(a_ovr)
  );

  scif_host_bridge #(.CLOCK_DIV(1), .POLL_INTERVAL(65535)) u_b (
    .core_clk(clk), .reset_reset_n(b_rst_n),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .scif_sclk(b_sclk), .scif_txd(b_txd), .scif_txr_n(b_txr_n),
    .scif_rxd(b_rxd), .scif_rxr_n(b_rxr_n), .busy(b_busy), .rx_overrun(b_ovr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_reset();
    a_rst_n = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_rxd = 1'b0;
    tick(); tick();
    a_rst_n = 1'b1;
  endtask

  // Runs one CLOCK_DIV=2 frame starting at its cycle 0; acts as the target on rxd.
  task automatic run_frame_a(input logic [8:0] tgt, output logic [8:0] txw,
                             output int bad, output logic rdy_last);
    logic prev_txd;
    logic rxr0;
    int   k;
    txw = 9'h000; bad = 0; k = 0;
    prev_txd = a_txd; rxr0 = a_rxr_n; rdy_last = 1'b0;
    for (int i = 0; i < 36; i++) begin
      if (a_sclk !== ((i % 4) >= 2)) bad++;
      if ((i % 4) != 0 && a_txd !== prev_txd) bad++;
      if (a_rxr_n !== rxr0 || a_busy !== 1'b1) bad++;
      prev_txd = a_txd;
      if ((i % 4) == 2) begin
        txw   = {txw[7:0], a_txd};
        a_rxd = tgt[8 - k];
        k++;
      end
      if (i == 35) rdy_last = a_in_ready;
      tick();
    end
    a_rxd = 1'b0;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_in_valid = 0; a_in_data = 0; a_out_ready = 0; a_txr_n = 1; a_rxd = 0;
    b_in_valid = 0; b_in_data = 0; b_out_ready = 0; b_txr_n = 1; b_rxd = 0;
    tick();
    n_tests++; if (a_sclk !== 1'b0) begin n_fail++; $display("FAIL rst_sclk got %b want 0", a_sclk); end
    n_tests++; if (a_txd !== 1'b0) begin n_fail++; $display("FAIL rst_txd got %b want 0", a_txd); end
    n_tests++; if (a_rxr_n !== 1'b1) begin n_fail++; $display("FAIL rst_rxr_n got %b want 1", a_rxr_n); end
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", a_in_ready); end
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", a_out_valid); end
    n_tests++; if (a_out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data got %h want 00", a_out_data); end
    n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", a_busy); end
    n_tests++; if (a_ovr !== 1'b0) begin n_fail++; $display("FAIL rst_overrun got %b want 0", a_ovr); end
    n_tests++; if ({b_sclk, b_txd, b_rxr_n, b_in_ready, b_out_valid, b_busy, b_ovr} !== 7'b0011000)
      begin n_fail++; $display("FAIL rst_b_outputs got %b want 0011000", {b_sclk, b_txd, b_rxr_n, b_in_ready, b_out_valid, b_busy, b_ovr}); end
    n_tests++; if (b_out_data !== 8'h00) begin n_fail++; $display("FAIL rst_b_out_data got %h want 00", b_out_data); end
    a_rst_n = 1'b1; b_rst_n = 1'b1;
  endtask

  task automatic test_tx_a5();
    logic [8:0] txw; int bad; logic rdy;
    a_txr_n = 1'b0;
    a_reset();
    tick(); tick();
    a_in_valid = 1'b1; a_in_data = 8'hA5;
    tick();
    a_in_valid = 1'b0;
    n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL a5_in_ready_after_load got %b want 0", a_in_ready); end
    n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL a5_busy_before_start got %b want 0", a_busy); end
    tick();
    n_tests++; if (a_busy !== 1'b1 || a_txd !== 1'b1) begin n_fail++; $display("FAIL a5_frame_start busy/txd got %b%b want 11", a_busy, a_txd); end
    run_frame_a(9'h000, txw, bad, rdy);
    n_tests++; if (txw !== 9'h1A5) begin n_fail++; $display("FAIL a5_txd_bits got %h want 1a5", txw); end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL a5_timing_violations got %0d want 0", bad); end
    n_tests++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL a5_in_ready_last_cycle got %b want 0", rdy); end
    n_tests++; if ({a_in_ready, a_busy, a_sclk, a_txd} !== 4'b1100) begin n_fail++; $display("FAIL a5_guard_entry rdy/busy/sclk/txd got %b want 1100", {a_in_ready, a_busy, a_sclk, a_txd}); end
    tick(); tick(); tick();
    n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL a5_guard_last got %b want 1", a_busy); end
    tick();
    n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL a5_idle_after_guard got %b want 0", a_busy); end
  endtask

  task automatic test_poll_rx();
    logic [8:0] txw; int bad; logic rdy;
    a_txr_n = 1'b0;
    a_reset();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (a_busy !== 1'b0) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL poll_early_frame got %0d want 0", bad); end
    tick();
    n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL poll_start got %b want 1", a_busy); end
    n_tests++; if (a_rxr_n !== 1'b0) begin n_fail++; $display("FAIL poll_rxr_n_in_frame got %b want 0", a_rxr_n); end
    run_frame_a(9'h15A, txw, bad, rdy);
    n_tests++; if (txw !== 9'h000) begin n_fail++; $display("FAIL poll_txd_bits got %h want 000", txw); end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL poll_timing_violations got %0d want 0", bad); end
    n_tests++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h5A) begin n_fail++; $display("FAIL poll_rx_byte got %b/%h want 1/5a", a_out_valid, a_out_data); end
    n_tests++; if (a_ovr !== 1'b0) begin n_fail++; $display("FAIL poll_no_overrun got %b want 0", a_ovr); end
    tick(); tick(); tick(); tick();
    n_tests++; if (a_rxr_n !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL poll_first_idle rxr_n/busy got %b%b want 00", a_rxr_n, a_busy); end
    tick();
    n_tests++; if (a_rxr_n !== 1'b1) begin n_fail++; $display("FAIL poll_rxr_n_blocked got %b want 1", a_rxr_n); end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (a_busy !== 1'b0 || a_rxr_n !== 1'b1 || a_out_valid !== 1'b1) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL poll_suppressed_while_full got %0d want 0", bad); end
  endtask

  task automatic test_overrun();
    logic [8:0] txw; int bad; logic rdy;
    a_in_valid = 1'b1; a_in_data = 8'h81;
    tick();
    a_in_valid = 1'b0;
    tick();
    n_tests++; if (a_busy !== 1'b1 || a_rxr_n !== 1'b1) begin n_fail++; $display("FAIL ovr_start busy/rxr_n got %b%b want 11", a_busy, a_rxr_n); end
    run_frame_a(9'h1C3, txw, bad, rdy);
    n_tests++; if (txw !== 9'h181) begin n_fail++; $display("FAIL ovr_txd_bits got %h want 181", txw); end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL ovr_timing_violations got %0d want 0", bad); end
    n_tests++; if (a_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse got %b want 1", a_ovr); end
    n_tests++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h5A) begin n_fail++; $display("FAIL ovr_data_kept got %b/%h want 1/5a", a_out_valid, a_out_data); end
    tick();
    n_tests++; if (a_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_pulse_width got %b want 0", a_ovr); end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_consume got %b want 0", a_out_valid); end
  endtask

  task automatic test_reset_mid();
    int bad;
    a_txr_n = 1'b0;
    a_reset();
    tick(); tick();
    a_in_valid = 1'b1; a_in_data = 8'hFF;
    tick();
    a_in_valid = 1'b0;
    tick();
    for (int i = 0; i < 18; i++) tick();
    n_tests++; if (a_sclk !== 1'b1 || a_busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre_reset sclk/busy got %b%b want 11", a_sclk, a_busy); end
    #1 a_rst_n = 1'b0;
    #1;
    n_tests++; if ({a_sclk, a_txd, a_rxr_n, a_in_ready, a_busy, a_out_valid} !== 6'b001100)
      begin n_fail++; $display("FAIL mid_async_reset got %b want 001100", {a_sclk, a_txd, a_rxr_n, a_in_ready, a_busy, a_out_valid}); end
    tick(); tick();
    a_rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_busy !== 1'b0 || a_sclk !== 1'b0 || a_in_ready !== 1'b1) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL mid_no_residual_frame got %0d want 0", bad); end
  endtask

  task automatic test_txr_hold();
    logic [8:0] txw; int bad;
    b_txr_n = 1'b1; b_rst_n = 1'b0;
    tick(); tick();
    b_rst_n = 1'b1;
    b_in_valid = 1'b1; b_in_data = 8'h3C;
    tick();
    b_in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (b_busy !== 1'b0 || b_in_ready !== 1'b0) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL txr_hold_no_frame got %0d want 0", bad); end
    b_txr_n = 1'b0;
    tick(); tick();
    n_tests++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL txr_sync_early got %b want 0", b_busy); end
    tick();
    n_tests++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL txr_start_4th_cycle got %b want 1", b_busy); end
    txw = 9'h000; bad = 0;
    for (int i = 0; i < 18; i++) begin
      if (b_sclk !== ((i % 2) == 1) || b_in_ready !== 1'b0) bad++;
      if ((i % 2) == 1) txw = {txw[7:0], b_txd};
      tick();
    end
    n_tests++; if (txw !== 9'h13C) begin n_fail++; $display("FAIL txr_txd_bits got %h want 13c", txw); end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL txr_frame_violations got %0d want 0", bad); end
    n_tests++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL txr_in_ready_after got %b want 1", b_in_ready); end
    tick(); tick();
    n_tests++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL txr_guard_len got %b want 0", b_busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    logic [8:0] frames [3];
    int         starts [3];
    logic [8:0] word;
    int nf, off, idx;
    logic prev_busy, active, drv_rdy;
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
    for (int j = 0; j < 3; j++) begin frames[j] = 9'h000; starts[j] = 0; end
    nf = 0; off = 0; idx = 0; word = 9'h000;
    prev_busy = b_busy; active = 1'b0; drv_rdy = 1'b0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (b_busy && !prev_busy && nf < 3) begin
        starts[nf] = cyc; active = 1'b1; off = 0; word = 9'h000;
      end
      prev_busy = b_busy;
      if (active) begin
        if ((off % 2) == 1) word = {word[7:0], b_txd};
        if (off == 17) begin frames[nf] = word; nf++; active = 1'b0; end
        off++;
      end
      if (b_in_valid && drv_rdy) idx++;
      drv_rdy    = b_in_ready;
      b_in_valid = (idx < 3);
      b_in_data  = (idx < 3) ? bytes[idx] : 8'h00;
      tick();
    end
    b_in_valid = 1'b0;
    n_tests++; if (nf !== 3) begin n_fail++; $display("FAIL b2b_frame_count got %0d want 3", nf); end
    for (int j = 0; j < 3; j++) begin
      n_tests++; if (frames[j] !== {1'b1, bytes[j]}) begin n_fail++; $display("FAIL b2b_payload%0d got %h want %h", j, frames[j], {1'b1, bytes[j]}); end
    end
    for (int j = 1; j < 3; j++) begin
      n_tests++; if (starts[j] - starts[j-1] !== 21) begin n_fail++; $display("FAIL b2b_spacing%0d got %0d want 21", j, starts[j] - starts[j-1]); end
    end
  endtask

  initial begin
    test_reset();
    test_tx_a5();
    test_poll_rx();
    test_overrun();
    test_reset_mid();
    test_txr_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
